restoring_divider: RTL and testbench

- Sequential unsigned integer divider, radix-2, restoring algorithm; inverse operation of the team's shift-add multiplier.
- Uses the same start/finished handshake and BITS parameterisation, so the two can share a testbench harness and control FSM style.
- Computes quotient and remainder of a BITS-wide dividend and divisor in BITS iteration cycles.

---
 rtl/restoring_divider.sv | 119 +++++++++++
 tb/tb_restoring_divider.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// Sequential radix-2 restoring divider: one quotient bit per clock, MSB first.
// Start/finished handshake with back-to-back acceptance from DONE.
module restoring_divider #(
  parameter int BITS = 4
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [BITS-1:0] i_dividend,
  input  logic [BITS-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_finished,
  output logic [BITS-1:0] o_quotient,
  output logic [BITS-1:0] o_remainder,
  output logic            o_div_by_zero
);

  localparam int CW = (BITS > 2) ? $clog2(BITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [BITS-1:0] rem_reg, rem_next;
  logic [BITS-1:0] dq_reg, dq_next;
  logic [BITS-1:0] divisor_reg, divisor_next;
  logic [BITS-1:0] quotient_reg, quotient_next;
  logic [BITS-1:0] remainder_reg, remainder_next;
  logic            dbz_reg, dbz_next;

  // The working remainder is BITS+1 bits only after the shift; between
  // iterations it is always below the divisor, so BITS bits are stored.
  logic [BITS:0]   partial;
  logic [BITS:0]   trial;
  logic            borrow;
  logic            last_iter;

  assign partial   = {rem_reg, dq_reg[BITS-1]};
  assign trial     = partial - {1'b0, divisor_reg};
  // partial < 2*divisor, so the trial lies in (-2^BITS, 2^BITS) and its
  // top bit is an exact borrow flag.
  assign borrow    = trial[BITS];
  assign last_iter = (count_reg == CW'(BITS - 1));

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_reg     <= S_IDLE;
      count_reg     <= '0;
      rem_reg       <= '0;
      dq_reg        <= '0;
      divisor_reg   <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      rem_reg       <= rem_next;
      dq_reg        <= dq_next;
      divisor_reg   <= divisor_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    rem_next       = rem_reg;
    dq_next        = dq_reg;
    divisor_next   = divisor_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_next   = S_RUN;
          count_next   = '0;
          rem_next     = '0;
          dq_next      = i_dividend;
          divisor_next = i_divisor;
        end else if (state_reg == S_DONE) begin
          state_next = S_IDLE;
        end
      end

      S_RUN: begin
        rem_next   = borrow ? partial[BITS-1:0] : trial[BITS-1:0];
        dq_next    = {dq_reg[BITS-2:0], ~borrow};
        count_next = count_reg + CW'(1);
        if (last_iter) begin
          state_next     = S_DONE;
          count_next     = '0;
          quotient_next  = {dq_reg[BITS-2:0], ~borrow};
          remainder_next = borrow ? partial[BITS-1:0] : trial[BITS-1:0];
          dbz_next       = (divisor_reg == '0);
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign o_busy        = (state_reg == S_RUN);
  assign o_finished    = (state_reg == S_DONE);
  assign o_quotient    = quotient_reg;
  assign o_remainder   = remainder_reg;
  assign o_div_by_zero = dbz_reg;

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider (BITS=4): stimulus pushes expected
// results, a monitor pops and compares on every o_finished pulse.
module tb_restoring_divider;

  localparam int BITS = 4;
  localparam int PERIOD = 10;

  logic            clk;
  logic            rst_n;
  logic            i_start;
  logic [BITS-1:0] i_dividend;
  logic [BITS-1:0] i_divisor;
  logic            o_busy;
  logic            o_finished;
  logic [BITS-1:0] o_quotient;
  logic [BITS-1:0] o_remainder;
  logic            o_div_by_zero;

  typedef struct packed {
    logic [BITS-1:0] q;
    logic [BITS-1:0] r;
    logic            z;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fin_count = 0;
  time  last_fin_time = 0;

  restoring_divider #(.BITS(BITS)) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_start      (i_start),
    .i_dividend   (i_dividend),
    .i_divisor    (i_divisor),
    .o_busy       (o_busy),
    .o_finished   (o_finished),
    .o_quotient   (o_quotient),
    .o_remainder  (o_remainder),
    .o_div_by_zero(o_div_by_zero)
  );

  initial clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic push_exp(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                          input logic [BITS-1:0] q, input logic [BITS-1:0] r,
                          input logic z);
    exp_t e;
    e.a = a; e.b = b; e.q = q; e.r = r; e.z = z;
    exp_q.push_back(e);
  endtask

  // Present operands with start for one accepting edge.
  task automatic start_op(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    @(negedge clk);
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  // Count negedges until o_finished, bounded.
  task automatic wait_done(output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (o_busy) busy_n++;
    end while (!o_finished && n < 30);
    if (!o_finished) begin
      checks++;
      errors++;
      $display("FAIL timeout: no o_finished after %0d cycles", n);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_finished) begin
        fin_count++;
        last_fin_time = $time;
        checks++;
        if (o_busy) begin
          errors++;
          $display("FAIL busy_with_finished: busy=%0b finished=%0b required busy=0", o_busy, o_finished);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_finish: q=%0d r=%0d dbz=%0b with no pending op",
                   o_quotient, o_remainder, o_div_by_zero);
        end else begin
          e = exp_q.pop_front();
          if (o_quotient !== e.q || o_remainder !== e.r || o_div_by_zero !== e.z) begin
            errors++;
            $display("FAIL result %0d/%0d: got q=%0d r=%0d dbz=%0b expected q=%0d r=%0d dbz=%0b",
                     e.a, e.b, o_quotient, o_remainder, o_div_by_zero, e.q, e.r, e.z);
          end else begin
            $display("op %0d/%0d -> q=%0d r=%0d dbz=%0b", e.a, e.b, o_quotient, o_remainder, o_div_by_zero);
          end
        end
      end
    end
  end

  initial begin
    int  n, busy_n, n2, fc;
    time t1;

    rst_n = 1'b0;
    i_start = 1'b0;
    i_dividend = '0;
    i_divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", o_busy, 0);
    check("reset_finished", o_finished, 0);
    check("reset_quotient", o_quotient, 0);
    check("reset_remainder", o_remainder, 0);
    check("reset_dbz", o_div_by_zero, 0);
    rst_n = 1'b1;

    // 11/5 with latency and busy-width checks, then hold
    push_exp(4'd11, 4'd5, 4'd2, 4'd1, 1'b0);
    start_op(4'd11, 4'd5);
    wait_done(n, busy_n);
    check("latency_11_5", n, BITS + 1);
    check("busy_cycles_11_5", busy_n, BITS);
    repeat (3) @(negedge clk);
    check("hold_quotient", o_quotient, 2);
    check("hold_remainder", o_remainder, 1);
    check("idle_busy", o_busy, 0);
    check("idle_finished", o_finished, 0);

    // Back-to-back with start held: 13/10 then 3/9
    @(negedge clk);
    i_dividend = 4'd13;
    i_divisor  = 4'd10;
    i_start    = 1'b1;
    push_exp(4'd13, 4'd10, 4'd1, 4'd3, 1'b0);
    @(posedge clk);
    wait_done(n, busy_n);
    t1 = last_fin_time;
    i_dividend = 4'd3;
    i_divisor  = 4'd9;
    push_exp(4'd3, 4'd9, 4'd0, 4'd3, 1'b0);
    @(posedge clk);
    #1 i_start = 1'b0;
    wait_done(n2, busy_n);
    check("b2b_spacing", int'((last_fin_time - t1) / PERIOD), BITS + 1);

    // Boundary operands
    push_exp(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    start_op(4'd15, 4'd1);
    wait_done(n, busy_n);
    push_exp(4'd0, 4'd7, 4'd0, 4'd0, 1'b0);
    start_op(4'd0, 4'd7);
    wait_done(n, busy_n);
    push_exp(4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
    start_op(4'd15, 4'd15);
    wait_done(n, busy_n);

    // Divide by zero, then a normal op clears the flag
    push_exp(4'd7, 4'd0, 4'd15, 4'd7, 1'b1);
    start_op(4'd7, 4'd0);
    wait_done(n, busy_n);
    check("latency_dbz", n, BITS + 1);
    push_exp(4'd6, 4'd3, 4'd2, 4'd0, 1'b0);
    start_op(4'd6, 4'd3);
    wait_done(n, busy_n);

    // Input changes and a start pulse during RUN are ignored
    push_exp(4'd9, 4'd2, 4'd4, 4'd1, 1'b0);
    start_op(4'd9, 4'd2);
    @(negedge clk);
    i_dividend = 4'd14;
    i_divisor  = 4'd3;
    i_start    = 1'b1;
    @(negedge clk);
    i_start    = 1'b0;
    wait_done(n, busy_n);
    check("midrun_latency", n, BITS - 1);

    // Reset on the 2nd RUN cycle abandons the op
    start_op(4'd12, 4'd5);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    fc = fin_count;
    @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_finished", o_finished, 0);
    check("rst_quotient", o_quotient, 0);
    check("rst_remainder", o_remainder, 0);
    check("rst_dbz", o_div_by_zero, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_no_finish", fin_count - fc, 0);

    // Sweep of every operand pair
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0)
          push_exp(BITS'(a), 4'd0, 4'd15, BITS'(a), 1'b1);
        else
          push_exp(BITS'(a), BITS'(b), BITS'(a / b), BITS'(a % b), 1'b0);
        start_op(BITS'(a), BITS'(b));
        wait_done(n, busy_n);
      end
    end

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
